// File: rtl/jeff_74x161_down_if.sv
// Pin bundle for the jeff_74x161_down presettable down counter.
// The master drives the control and data pins; the counter (slave) drives the count and the borrow.
interface jeff_74x161_down_if;
   logic ld;
   logic ent;
   logic enp;
   logic a;
   logic b;
   logic c;
   logic d;
   logic qa;
   logic qb;
   logic qc;
   logic qd;
   logic rbo;

   modport master (
      output ld, ent, enp, a, b, c, d,
      input  qa, qb, qc, qd, rbo
   );

   modport slave (
      input  ld, ent, enp, a, b, c, d,
      output qa, qb, qc, qd, rbo
   );
endinterface

// File: rtl/jeff_74x161_down.sv
// Synchronous presettable 4-bit down counter with dual enables and programmable modulus.
// Underflow from 0 reloads MOD-1; rbo flags the zero state for cascading stages.
module jeff_74x161_down #(
   parameter int MOD = 16
) (
   input logic               clk,
   input logic               clr,
   jeff_74x161_down_if.slave bus
);

   localparam logic [3:0] WRAP_VAL = 4'(MOD - 1);

   logic [3:0] q_r;
   logic [3:0] q_next_s;
   logic       zero_s;

   assign zero_s = (q_r == 4'd0);

   // next-state selection: clear, then load, then count, else hold
   always_comb begin
      q_next_s = q_r;
      if (clr) begin
         q_next_s = 4'd0;
      end else if (bus.ld) begin
         q_next_s = {bus.d, bus.c, bus.b, bus.a};
      end else if (bus.ent && bus.enp) begin
         if (zero_s) begin
            q_next_s = WRAP_VAL;
         end else begin
            q_next_s = q_r - 4'd1;
         end
      end else begin
         q_next_s = q_r;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      q_r <= q_next_s;
   end

   assign {bus.qd, bus.qc, bus.qb, bus.qa} = q_r;
   // borrow is gated by ent only so a higher stage sees it without waiting a cycle
   assign bus.rbo = bus.ent & zero_s;

endmodule

// File: tb/tb_jeff_74x161_down.sv
// Scoreboard bench for jeff_74x161_down: MOD=16 and MOD=10 singles plus a two-stage cascade.
// Stimulus pushes expected {q, rbo} records; a separate monitor pops and compares them.
module tb_jeff_74x161_down;

   typedef struct {
      string      name;
      int         unit;
      logic [3:0] q;
      logic       rbo;
   } exp_t;

   logic clk;
   logic clr_a;
   logic clr_b;
   logic clr_c;
   int   errors;
   int   checks;
   exp_t sb[$];
   event check_ev;

   jeff_74x161_down_if if16 ();
   jeff_74x161_down_if if10 ();
   jeff_74x161_down_if ifl ();
   jeff_74x161_down_if ifh ();

   jeff_74x161_down #(.MOD(16)) u16 (.clk(clk), .clr(clr_a), .bus(if16));
   jeff_74x161_down #(.MOD(10)) u10 (.clk(clk), .clr(clr_b), .bus(if10));
   jeff_74x161_down #(.MOD(16)) ulo (.clk(clk), .clr(clr_c), .bus(ifl));
   jeff_74x161_down #(.MOD(16)) uhi (.clk(clk), .clr(clr_c), .bus(ifh));

   assign ifh.ent = ifl.rbo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void expect_v(string nm, int unit, logic [3:0] q, logic r);
      exp_t e;
      e.name = nm;
      e.unit = unit;
      e.q    = q;
      e.rbo  = r;
      sb.push_back(e);
   endfunction

   function automatic logic [4:0] actual(int unit);
      case (unit)
         0:       return {if16.rbo, if16.qd, if16.qc, if16.qb, if16.qa};
         1:       return {if10.rbo, if10.qd, if10.qc, if10.qb, if10.qa};
         2:       return {ifl.rbo, ifl.qd, ifl.qc, ifl.qb, ifl.qa};
         default: return {ifh.rbo, ifh.qd, ifh.qc, ifh.qb, ifh.qa};
      endcase
   endfunction

   // monitor: drains the scoreboard each time the stimulus marks outputs as presented
   initial begin
      exp_t       e;
      logic [4:0] act;
      forever begin
         @(check_ev);
         while (sb.size() != 0) begin
            e   = sb.pop_front();
            act = actual(e.unit);
            checks = checks + 1;
            if (act[3:0] !== e.q) begin
               errors = errors + 1;
               $display("FAIL %s: unit %0d q=%0d, expected %0d", e.name, e.unit, act[3:0], e.q);
            end
            checks = checks + 1;
            if (act[4] !== e.rbo) begin
               errors = errors + 1;
               $display("FAIL %s_rbo: unit %0d rbo=%0b, expected %0b", e.name, e.unit, act[4], e.rbo);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic present();
      -> check_ev;
      #1;
   endtask

   initial begin
      logic [3:0] ev;
      logic [3:0] seq16 [5];
      errors = 0;
      checks = 0;
      seq16[0] = 4'd3; seq16[1] = 4'd2; seq16[2] = 4'd1; seq16[3] = 4'd0; seq16[4] = 4'd15;
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      if16.ld = 1'b0; if16.ent = 1'b0; if16.enp = 1'b0; {if16.d, if16.c, if16.b, if16.a} = 4'd0;
      if10.ld = 1'b0; if10.ent = 1'b0; if10.enp = 1'b0; {if10.d, if10.c, if10.b, if10.a} = 4'd0;
      ifl.ld = 1'b0; ifl.ent = 1'b0; ifl.enp = 1'b0; {ifl.d, ifl.c, ifl.b, ifl.a} = 4'd0;
      ifh.ld = 1'b0; ifh.enp = 1'b0; {ifh.d, ifh.c, ifh.b, ifh.a} = 4'd0;
      #1;

      // reset: clr beats a load of 1010 with both enables high
      clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
      if16.ld = 1'b1; if16.ent = 1'b1; if16.enp = 1'b1; {if16.d, if16.c, if16.b, if16.a} = 4'b1010;
      tick();
      expect_v("rst_q", 0, 4'd0, 1'b1);
      expect_v("rst_u10", 1, 4'd0, 1'b0);
      expect_v("rst_lo", 2, 4'd0, 1'b0);
      present();
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      if16.ld = 1'b0; if16.ent = 1'b0; if16.enp = 1'b0;
      #1;
      expect_v("rst_ent0", 0, 4'd0, 1'b0);
      present();

      // load 0011 with enables high (load wins), then count through the 0 -> 15 wrap
      if16.ld = 1'b1; if16.ent = 1'b1; if16.enp = 1'b1; {if16.d, if16.c, if16.b, if16.a} = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_v("count16", 0, seq16[i], (seq16[i] == 4'd0));
         present();
         if16.ld = 1'b0;
      end

      // enable gating
      if16.ld = 1'b1; {if16.d, if16.c, if16.b, if16.a} = 4'b0101;
      tick();
      if16.ld = 1'b0; if16.ent = 1'b1; if16.enp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_v("hold_enp0", 0, 4'd5, 1'b0);
         present();
      end
      if16.ent = 1'b0; if16.enp = 1'b1;
      tick();
      expect_v("hold_ent0", 0, 4'd5, 1'b0);
      present();
      if16.ld = 1'b1; {if16.d, if16.c, if16.b, if16.a} = 4'b0000;
      tick();
      expect_v("load0_ent0", 0, 4'd0, 1'b0);
      present();
      if16.ld = 1'b0; if16.ent = 1'b1; if16.enp = 1'b0;
      #1;
      expect_v("rbo_comb", 0, 4'd0, 1'b1);
      present();
      tick();
      expect_v("rbo_enp0", 0, 4'd0, 1'b1);
      present();

      // modulus-10 unit: wrap reloads 9; out-of-range load drains once then stays below 10
      if10.ld = 1'b1; {if10.d, if10.c, if10.b, if10.a} = 4'b0010;
      tick();
      expect_v("mod10_load", 1, 4'd2, 1'b0);
      present();
      if10.ld = 1'b0; if10.ent = 1'b1; if10.enp = 1'b1;
      seq16[0] = 4'd1; seq16[1] = 4'd0; seq16[2] = 4'd9; seq16[3] = 4'd8;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_v("mod10_wrap", 1, seq16[i], (seq16[i] == 4'd0));
         present();
      end
      if10.ld = 1'b1; {if10.d, if10.c, if10.b, if10.a} = 4'b1111;
      tick();
      expect_v("mod10_ld15", 1, 4'd15, 1'b0);
      present();
      if10.ld = 1'b0;
      for (int i = 1; i <= 26; i++) begin
         tick();
         ev = (i <= 15) ? 4'(15 - i) : 4'(9 - ((i - 16) % 10));
         expect_v("mod10_drain", 1, ev, (ev == 4'd0));
         present();
      end

      // priority
      if16.ent = 1'b1; if16.enp = 1'b1;
      clr_a = 1'b1; if16.ld = 1'b1; {if16.d, if16.c, if16.b, if16.a} = 4'b1111;
      tick();
      expect_v("clr_ld", 0, 4'd0, 1'b1);
      present();
      clr_a = 1'b0; {if16.d, if16.c, if16.b, if16.a} = 4'b0111;
      tick();
      expect_v("ld_over_cnt", 0, 4'd7, 1'b0);
      present();
      if16.ld = 1'b0; if16.ent = 1'b0; if16.enp = 1'b0;
      tick();
      expect_v("hold7", 0, 4'd7, 1'b0);
      present();
      clr_a = 1'b1; if16.ld = 1'b1; if16.ent = 1'b1; if16.enp = 1'b1;
      {if16.d, if16.c, if16.b, if16.a} = 4'b0101;
      #1;
      expect_v("clr_noedge", 0, 4'd7, 1'b0);
      present();
      tick();
      expect_v("clr_midcnt", 0, 4'd0, 1'b1);
      present();
      clr_a = 1'b0;

      // cascade: low rbo feeds high ent, enp shared
      ifl.ent = 1'b1; ifl.enp = 1'b1; ifh.enp = 1'b1;
      ifl.ld = 1'b1; ifh.ld = 1'b1;
      {ifl.d, ifl.c, ifl.b, ifl.a} = 4'h0; {ifh.d, ifh.c, ifh.b, ifh.a} = 4'h1;
      tick();
      expect_v("casc10_lo", 2, 4'h0, 1'b1);
      expect_v("casc10_hi", 3, 4'h1, 1'b0);
      present();
      ifl.ld = 1'b0; ifh.ld = 1'b0;
      tick();
      expect_v("casc0f_lo", 2, 4'hF, 1'b0);
      expect_v("casc0f_hi", 3, 4'h0, 1'b0);
      present();
      tick();
      expect_v("casc0e_lo", 2, 4'hE, 1'b0);
      expect_v("casc0e_hi", 3, 4'h0, 1'b0);
      present();
      ifl.ld = 1'b1; ifh.ld = 1'b1;
      {ifh.d, ifh.c, ifh.b, ifh.a} = 4'h0;
      tick();
      expect_v("casc00_lo", 2, 4'h0, 1'b1);
      expect_v("casc00_hi", 3, 4'h0, 1'b1);
      present();
      ifl.ld = 1'b0; ifh.ld = 1'b0;
      tick();
      expect_v("cascff_lo", 2, 4'hF, 1'b0);
      expect_v("cascff_hi", 3, 4'hF, 1'b0);
      present();

      #1;
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jeff_74x161_down.md
Name: jeff_74x161_down

Overview:
- Synchronous presettable 4-bit binary down counter. It is the count-down counterpart of the team's 4-bit up counter (jeff_74x161).
- Same pin style: parallel load, dual count enables (ENT/ENP), and a cascadable ripple borrow output for building multi-stage down counters, timers and dividers.
- Programmable modulus: on wrap it reloads MOD-1 instead of always reloading 15.

Parameters:
- MOD, 16: counter modulus, legal range 2..16. Underflow from 0 wraps to MOD-1.

Ports:
- clk  input  1  clock; all state changes on rising edge
- clr  input  1  reset; synchronous, active-high
- ld  input  1  synchronous parallel load, active-high
- ent  input  1  enable T, active-high; gates count and rbo
- enp  input  1  enable P, active-high; gates count only
- a, b, c, d  input  1 each  parallel data in; a = LSB, d = MSB
- qa, qb, qc, qd  output  1 each  count out; qa = LSB, qd = MSB
- rbo  output  1  ripple borrow out, active-high

Behaviour:
- State: one 4-bit register Q; {qd,qc,qb,qa} = Q. No other state.
- Priority at each rising clk edge:
  1. clr=1: Q <= 0.
  2. Else ld=1: Q <= {d,c,b,a}. Load ignores ent/enp.
  3. Else ent=1 and enp=1: if Q==0 then Q <= MOD-1, else Q <= Q-1.
  4. Else: Q holds.
- Reset: clr is synchronous only. An asserted clr with no clk edge does not change Q. After the reset edge: qa..qd = 0 and rbo = ent (Q==0).
- rbo = ent & (Q==0). Purely combinational from registered Q and ent; no clk latency. enp does not affect rbo.
- Latency: load and count take effect at the edge; outputs are valid the same cycle after the edge.
- Load values of MOD or higher (when MOD<16) are accepted as-is. The counter counts down normally to 0, then wraps to MOD-1; after one pass it never exceeds MOD-1.
- MOD=16: plain 4-bit wrap, 0 -> 15.
- clr and ld together: clr wins, Q=0.
- ld with ent=enp=1: load wins; no decrement that cycle.
- Cascading: lower-stage rbo drives the upper-stage ent; enp is common to all stages. The upper stage decrements only when the lower stage is 0 and counting, giving a synchronous multi-stage down count.
- clr asserted mid-count: next edge forces 0 regardless of ld/ent/enp.
- No X propagation from unused states; all 16 Q values are defined.
- Synthesisable; no latches, no async logic, single clock domain.

Test Plan:
- Reset: clr=1 for one edge with ld=1, data=1010, ent=enp=1 -> Q=0000; rbo=1 while ent=1, rbo=0 when ent=0.
- Load then count (MOD=16): load 0011, then ent=enp=1 for 5 edges -> Q = 3,2,1,0,15. rbo=1 only in the Q=0 cycle.
- Enable gating: Q=0101. ent=1/enp=0 for 3 edges -> holds 5. ent=0/enp=1 -> holds 5. Load 0000 with ent=0 -> rbo=0, then ent=1 -> rbo=1 with no clk edge.
- Modulus (MOD=10): load 0010, count 4 edges -> 2,1,0,9,8. Load 1111 and count -> 15..0, then 9; 10..15 never reappear.
- Priority: clr=ld=1 -> 0. ld=1, ent=enp=1, data=0111 -> 7, not 6. clr asserted between edges with no edge -> Q unchanged until the next edge.
- Cascade: two instances (MOD=16), low rbo -> high ent, shared enp=1, load 0x10 -> sequence 0x10, 0x0F, 0x0E. Load 0x00, count once -> 0xFF; high rbo=1 only when both stages are 0.
